// File: rtl/tdc_event_merger.sv
// rtl/tdc_event_merger.sv - round-robin merge of TDC channel timestamps into one CSR-visible FIFO
// Optional: define TDC_MERGER_DROPCNT_EN for the saturating drop counter at register 5.
module tdc_event_merger #(
    parameter logic [3:0] csr_addr   = 4'h2,
    parameter int         NCH        = 2,
    parameter int         TS_W       = 32,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NCH-1:0]      ch_valid_i,
    input  logic [NCH*TS_W-1:0] ch_ts_i,
    input  logic [NCH-1:0]      ch_pol_i,
    output logic [NCH-1:0]      ch_ack_o,
    input  logic [13:0]         csr_a,
    input  logic                csr_we,
    input  logic [31:0]         csr_di,
    output logic [31:0]         csr_do,
    output logic                irq
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int ENT_W = TS_W + 5;
    localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

    logic [NCH-1:0]        enable;
    logic                  irq_en;
    logic                  overflow;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic [3:0]            rr_last;
    logic [ENT_W-1:0]      mem [DEPTH];
    logic [ENT_W-1:0]      head;

    logic [NCH-1:0]        req, gnt;
    logic                  gnt_any;
    logic [3:0]            gnt_chan;
    logic                  push_pol;
    logic [TS_W-1:0]       push_ts;

    logic       sel, wr, flush, empty, full, do_pop, do_push, drop;
    logic [2:0] reg_idx;
    logic [31:0] rdata;
    logic       unused_ok;

    assign req = ch_valid_i & enable;

    // Two passes: channels above the last grant first, then wrap to the rest.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_chan = '0;
        push_pol = 1'b0;
        push_ts  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!gnt_any && req[i] && i > int'(rr_last)) begin
                gnt_any  = 1'b1;
                gnt[i]   = 1'b1;
                gnt_chan = 4'(i);
                push_pol = ch_pol_i[i];
                push_ts  = ch_ts_i[i*TS_W +: TS_W];
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!gnt_any && req[i] && i <= int'(rr_last)) begin
                gnt_any  = 1'b1;
                gnt[i]   = 1'b1;
                gnt_chan = 4'(i);
                push_pol = ch_pol_i[i];
                push_ts  = ch_ts_i[i*TS_W +: TS_W];
            end
        end
    end

    // Disabled channels are drained every cycle so their cores never stall.
    assign ch_ack_o = sys_rst ? '0 : (gnt | (ch_valid_i & ~enable));

    assign sel     = (csr_a[13:10] == csr_addr);
    assign reg_idx = csr_a[2:0];
    assign wr      = sel & csr_we;
    assign flush   = wr && (reg_idx == 3'd0) && csr_di[31];
    assign empty   = (level == '0);
    assign full    = (level == FULL_LVL);
    assign do_pop  = wr && (reg_idx == 3'd4) && !empty;
    assign do_push = gnt_any && !flush && !sys_rst && (!full || do_pop);
    assign drop    = gnt_any && !flush && full && !do_pop;
    assign head    = mem[rd_ptr];

`ifdef TDC_MERGER_DROPCNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            drop_cnt <= '0;
        else if (wr && reg_idx == 3'd5)
            drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    always_comb begin
        rdata = '0;
        case (reg_idx)
            3'd0: begin
                rdata[NCH-1:0] = enable;
                rdata[30]      = irq_en;
            end
            3'd1: begin
                rdata[DEPTH_LOG2:0] = level;
                rdata[16]           = empty;
                rdata[17]           = full;
                rdata[18]           = overflow;
            end
            3'd2: if (!empty) rdata[TS_W-1:0] = head[TS_W-1:0];
            3'd3: if (!empty) begin
                rdata[3:0] = head[TS_W+3:TS_W];
                rdata[4]   = head[ENT_W-1];
                rdata[31]  = 1'b1;
            end
`ifdef TDC_MERGER_DROPCNT_EN
            3'd5: rdata[15:0] = drop_cnt;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            enable   <= '0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rr_last  <= '0;
            csr_do   <= '0;
            irq      <= 1'b0;
        end else begin
            csr_do <= sel ? rdata : '0;
            irq    <= irq_en & ~empty;
            if (gnt_any)
                rr_last <= gnt_chan;
            // A flush write leaves the enable and irq_en fields untouched.
            if (wr && reg_idx == 3'd0 && !csr_di[31]) begin
                enable <= csr_di[NCH-1:0];
                irq_en <= csr_di[30];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= wr_ptr + PTR_ONE;
                if (do_pop)
                    rd_ptr <= rd_ptr + PTR_ONE;
                if (do_push && !do_pop)
                    level <= level + LVL_ONE;
                else if (!do_push && do_pop)
                    level <= level - LVL_ONE;
            end
            if (drop)
                overflow <= 1'b1;
            else if (wr && reg_idx == 3'd1 && csr_di[18])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push)
            mem[wr_ptr] <= {push_pol, gnt_chan, push_ts};
    end

    assign unused_ok = ^{csr_a[9:3], csr_di};

endmodule

// File: tb/tb_tdc_event_merger.sv
// tb/tb_tdc_event_merger.sv - self-checking bench for tdc_event_merger against a queue model
module tb_tdc_event_merger;
    localparam int NCH = 2;
    localparam int TS_W = 32;
    localparam int DL2 = 2;
    localparam int DEPTH = 4;
    localparam logic [3:0] SLOT = 4'h2;

    logic                sys_clk = 1'b0;
    logic                sys_rst = 1'b1;
    logic [NCH-1:0]      ch_valid_i = '0;
    logic [NCH*TS_W-1:0] ch_ts_i = '0;
    logic [NCH-1:0]      ch_pol_i = '0;
    logic [NCH-1:0]      ch_ack_o;
    logic [13:0]         csr_a = '0;
    logic                csr_we = 1'b0;
    logic [31:0]         csr_di = '0;
    logic [31:0]         csr_do;
    logic                irq;

    always #5 sys_clk = ~sys_clk;

    tdc_event_merger #(.csr_addr(SLOT), .NCH(NCH), .TS_W(TS_W), .DEPTH_LOG2(DL2)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .ch_valid_i(ch_valid_i), .ch_ts_i(ch_ts_i),
        .ch_pol_i(ch_pol_i), .ch_ack_o(ch_ack_o), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(csr_do), .irq(irq)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: queue of {pol, chan, ts} entries plus control flags.
    logic [NCH-1:0] m_en;
    logic           m_irq_en, m_ovf, m_irq;
    logic [36:0]    m_q[$];
    int             m_last;
    int             m_drop;
    logic [31:0]    m_do;
    bit             chk_on = 1'b0;

    function automatic int m_pick();
        if (sys_rst) return -1;
        for (int k = 1; k <= NCH; k++) begin
            int idx;
            idx = (m_last + k) % NCH;
            if (ch_valid_i[idx] && m_en[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] m_ack();
        logic [NCH-1:0] a;
        int g;
        if (sys_rst) return '0;
        a = ch_valid_i & ~m_en;
        g = m_pick();
        if (g >= 0) a[g] = 1'b1;
        return a;
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] a);
        int n;
        n = m_q.size();
        if (a[13:10] != SLOT) return 32'h0;
        case (a[2:0])
            3'd0: return {1'b0, m_irq_en, 28'b0, m_en};
            3'd1: return 32'(n) | ((n == 0) ? 32'h10000 : 32'h0) |
                         ((n == DEPTH) ? 32'h20000 : 32'h0) | (m_ovf ? 32'h40000 : 32'h0);
            3'd2: return (n == 0) ? 32'h0 : m_q[0][31:0];
            3'd3: return (n == 0) ? 32'h0 : {1'b1, 26'b0, m_q[0][36], m_q[0][35:32]};
`ifdef TDC_MERGER_DROPCNT_EN
            3'd5: return 32'(m_drop);
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge sys_clk) begin : model
        int g;
        bit w, fl, pop, was_full, dropped;
        logic [36:0] e;
        if (sys_rst) begin
            m_en = '0; m_irq_en = 1'b0; m_ovf = 1'b0; m_q.delete();
            m_last = 0; m_drop = 0; m_do = '0; m_irq = 1'b0; chk_on = 1'b1;
        end else begin
            m_do  = m_read(csr_a);
            m_irq = m_irq_en && (m_q.size() != 0);
            g = m_pick();
            w = (csr_a[13:10] == SLOT) && csr_we;
            fl = w && (csr_a[2:0] == 3'd0) && csr_di[31];
            dropped = 1'b0;
            if (fl) begin
                m_q.delete();
            end else begin
                pop = w && (csr_a[2:0] == 3'd4) && (m_q.size() != 0);
                was_full = (m_q.size() == DEPTH);
                if (pop) void'(m_q.pop_front());
                if (g >= 0) begin
                    e = {ch_pol_i[g], 4'(g), ch_ts_i[g*TS_W +: TS_W]};
                    if (!was_full || pop) m_q.push_back(e);
                    else begin
                        m_ovf = 1'b1;
                        dropped = 1'b1;
                        if (m_drop < 16'hFFFF) m_drop++;
                    end
                end
            end
            if (w && csr_a[2:0] == 3'd1 && csr_di[18] && !dropped) m_ovf = 1'b0;
            if (w && csr_a[2:0] == 3'd0 && !csr_di[31]) begin
                m_en = csr_di[NCH-1:0];
                m_irq_en = csr_di[30];
            end
            if (w && csr_a[2:0] == 3'd5) m_drop = 0;
            if (g >= 0) m_last = g;
        end
    end

    always @(negedge sys_clk) begin
        if (chk_on) begin
            chk("ack", 32'(ch_ack_o), 32'(m_ack()));
            chk("csr_do", csr_do, m_do);
            chk("irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] r);
        csr_a = {SLOT, 7'b0, r};
        csr_we = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [2:0] r, input logic [31:0] d);
        csr_a = {SLOT, 7'b0, r};
        csr_we = 1'b1;
        csr_di = d;
        tick();
        csr_we = 1'b0;
        csr_di = '0;
    endtask

    logic [1:0]  rr_exp [4];
    logic [31:0] exp_drop;

    initial begin
        rr_exp = '{2'b10, 2'b01, 2'b10, 2'b01};
`ifdef TDC_MERGER_DROPCNT_EN
        exp_drop = 32'd2;
`else
        exp_drop = 32'd0;
`endif
        repeat (3) tick();
        sys_rst = 1'b0;

        rd(3'd0); chk("rst CTRL", csr_do, 32'h0);
        rd(3'd1); chk("rst STATUS", csr_do, 32'h00010000);
        rd(3'd2); chk("rst TS", csr_do, 32'h0);
        rd(3'd3); chk("rst META", csr_do, 32'h0);
        chk("rst irq", 32'(irq), 32'h0);

        ch_valid_i = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1; chk("ack disabled", 32'(ch_ack_o), 32'h3);
            tick();
        end
        ch_valid_i = 2'b00;
        rd(3'd1); chk("disabled level", csr_do, 32'h00010000);

        wr(3'd0, 32'h3);
        ch_ts_i = {32'h200, 32'h100};
        ch_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1; chk("ack rr", 32'(ch_ack_o), 32'(rr_exp[i]));
            tick();
        end
        ch_valid_i = 2'b00;
        rd(3'd1); chk("rr STATUS", csr_do, 32'h00020004);
        rd(3'd3); chk("rr META0", csr_do, 32'h80000001);
        rd(3'd2); chk("rr TS0", csr_do, 32'h200);
        wr(3'd4, 32'h0);
        rd(3'd3); chk("rr META1", csr_do, 32'h80000000);
        wr(3'd0, 32'h80000003);
        rd(3'd1); chk("flush STATUS", csr_do, 32'h00010000);

        wr(3'd0, 32'h40000003);
        ch_ts_i = {32'hDEADBEEF, 32'h0};
        ch_pol_i = 2'b10;
        ch_valid_i = 2'b10;
        csr_a = {SLOT, 7'b0, 3'd2};
        #1; chk("ack single", 32'(ch_ack_o), 32'h2);
        tick();
        chk("irq edge k", 32'(irq), 32'h0);
        ch_valid_i = 2'b00;
        tick();
        chk("irq edge k+1", 32'(irq), 32'h1);
        chk("TS beef", csr_do, 32'hDEADBEEF);
        rd(3'd3); chk("META beef", csr_do, 32'h80000011);
        wr(3'd4, 32'h0);
        rd(3'd1); chk("pop STATUS", csr_do, 32'h00010000);
        chk("irq fall", 32'(irq), 32'h0);

        wr(3'd0, 32'h3);
        ch_pol_i = 2'b00;
        ch_ts_i = {32'h22, 32'h11};
        ch_valid_i = 2'b11;
        repeat (6) tick();
        ch_valid_i = 2'b00;
        rd(3'd1); chk("ovf STATUS", csr_do, 32'h00060004);
        rd(3'd5); chk("DROPCNT", csr_do, exp_drop);
        wr(3'd1, 32'h00040000);
        rd(3'd1); chk("w1c STATUS", csr_do, 32'h00020004);
        ch_valid_i = 2'b01;
        wr(3'd4, 32'h0);
        ch_valid_i = 2'b00;
        rd(3'd1); chk("pop+push full", csr_do, 32'h00020004);
        wr(3'd5, 32'h0);
        rd(3'd5); chk("DROPCNT clr", csr_do, 32'h0);

        wr(3'd0, 32'h80000003);
        ch_valid_i = 2'b11;
        repeat (3) tick();
        ch_valid_i = 2'b00;
        rd(3'd1); chk("fill3 STATUS", csr_do, 32'h00000003);
        ch_valid_i = 2'b01;
        wr(3'd0, 32'h80000003);
        ch_valid_i = 2'b00;
        rd(3'd1); chk("flush push lost", csr_do, 32'h00010000);
        rd(3'd0); chk("flush keeps en", csr_do, 32'h00000003);

        csr_a = {4'h3, 7'b0, 3'd0};
        tick();
        chk("other slot", csr_do, 32'h0);

        ch_valid_i = 2'b11;
        repeat (3) tick();
        sys_rst = 1'b1;
        #1; chk("ack in reset", 32'(ch_ack_o), 32'h0);
        tick();
        tick();
        sys_rst = 1'b0;
        ch_valid_i = 2'b00;
        rd(3'd1); chk("post-rst STATUS", csr_do, 32'h00010000);
        rd(3'd0); chk("post-rst CTRL", csr_do, 32'h0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_event_merger.md
# tdc_event_merger

N-channel timestamp collector for the TDC subsystem. Accepts finished timestamps from up to 16 TDC channel cores, merges them through a round-robin arbiter into one shared FIFO, and exposes the FIFO, channel enables and status on the CSR bus with a single level interrupt. It replaces the per-channel Wishbone slaves and per-channel interrupt lines: the CPU services every channel through one CSR slot.

## Interface
- csr_addr, 4'h2: CSR slot; block selected when csr_a[13:10] == csr_addr
- NCH, 2: channel count, 1..16
- TS_W, 32: timestamp width, 1..32
- DEPTH_LOG2, 4: FIFO depth is 2^DEPTH_LOG2 entries

- sys_clk  in  1  system clock; the block uses only this clock
- sys_rst  in  1  reset, synchronous, active-high
- ch_valid_i  in  NCH  channel i presents an event
- ch_ts_i  in  NCH*TS_W  timestamp for channel i, in bits [i*TS_W +: TS_W]
- ch_pol_i  in  NCH  edge polarity for channel i (1 = rising)
- ch_ack_o  out  NCH  event on channel i consumed this cycle
- csr_a  in  14  CSR address
- csr_we  in  1  CSR write strobe
- csr_di  in  32  CSR write data
- csr_do  out  32  CSR read data, registered
- irq  out  1  level interrupt

## Operation
- FIFO entry is {pol, chan[3:0], ts[TS_W-1:0]}.
- Register map, selected by csr_a[2:0]:
  - 0 CTRL (R/W): [NCH-1:0] channel enables; [30] irq_en; [31] flush, write-only and self-clearing, reads 0.
  - 1 STATUS (R, W1C): [DEPTH_LOG2:0] level; [16] empty; [17] full; [18] overflow (sticky). Writing 1 to bit 18 clears overflow.
  - 2 TS (R): head timestamp, zero-extended to 32 bits; 0 when the FIFO is empty.
  - 3 META (R): [3:0] channel; [4] polarity; [31] head valid (= not empty).
  - 4 POP (W): any write removes the head entry. A write when the FIFO is empty does nothing.
  - 5 DROPCNT: see Configuration.
  - 6, 7: read 0, writes ignored.
- Reads have no side effects.
- Arbiter:
  - Request set is req = ch_valid_i & enable.
  - Round-robin: the search starts at the channel after the last granted channel. At most one grant per cycle.
  - ch_ack_o[g] = 1 for the granted channel. Ungranted requesters hold ch_ack_o low and keep their event.
- Disabled channel with valid high: ch_ack_o is asserted every cycle. The event is discarded and is not counted as a drop.
- FIFO full with no pop in the same cycle: the granted event is acked but not written, and overflow is set.
- Full FIFO with a pop in the same cycle: the push is accepted and the level is unchanged.
- Flush: read and write pointers clear, the level goes to 0, and any push or pop in that cycle is ignored. Enables and overflow are unchanged.
- irq = irq_en & ~empty, registered.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo the depth. The level counter is DEPTH_LOG2+1 bits wide.

## Timing
- Reset values: all enables 0; irq_en 0; FIFO empty; overflow 0; csr_do 0; irq 0. ch_ack_o is forced to 0 while sys_rst is high.
- Reset asserted mid-operation clears the FIFO contents and the round-robin pointer on that edge.
- ch_ack_o is combinational from ch_valid_i, the enables, and the arbiter pointer. The event is captured on the same sys_clk edge on which ack is high.
- Push to visible: an entry pushed at edge k appears in the level and in the head registers for a read with csr_a presented after edge k. Latency is 1 cycle from ack to empty=0. irq rises 1 cycle later (edge k+1).
- csr_do is registered: data for csr_a at edge k is valid after edge k. csr_do is 0 when the slot is not selected.
- A POP write at edge k updates the head and level on edge k.

## Configuration
- TDC_MERGER_DROPCNT_EN defined:
  - Register 5 is a 16-bit saturating count of events dropped because the FIFO was full.
  - It does not wrap past 16'hFFFF.
  - Any write to register 5 clears it. Reset value is 0.
- Not defined: register 5 reads 0, writes are ignored, and only the sticky overflow flag reports drops.

## Test plan
- Reset, then read all registers: CTRL=0, STATUS=0x00010000, TS=0, META=0, irq=0. Drive ch_valid_i=2'b11 with enables=0: ch_ack_o=2'b11 every cycle, level stays 0.
- Enable both channels, hold ch_valid_i=2'b11 with ts0=0x100 and ts1=0x200 for 4 cycles: grants alternate, ack pattern is 01,10,01,10 or 10,01,10,01, level=4, META channel order alternates.
- Push 1 event (ch1, ts=0xDEADBEEF, pol=1) with irq_en=1: irq=1 two edges after ack, TS=0xDEADBEEF, META=0x80000011. Write POP: level=0, irq falls.
- DEPTH_LOG2=2: push 6 events with no pops: level=4, full=1, overflow=1, and DROPCNT=2 when TDC_MERGER_DROPCNT_EN is defined. W1C bit 18 clears overflow. Pop and push in the same cycle while full: level stays 4.
- Fill 3 entries, then write CTRL with bit31=1 while a push is pending in the same cycle: level=0, empty=1, enables are kept, and the pending push is lost.
- Assert sys_rst with 3 entries queued and ch_valid_i high: ch_ack_o=0 during reset, and after reset level=0 and enables=0.
